// File: rtl/cpu6_div_pkg.sv
// Shared constants for the cpu6 divider: data width, DIVOP codes and the
// RISC-V special-case result helper.
package cpu6_div_pkg;

    localparam int CPU6_XLEN = 32;

    localparam logic [1:0] CPU6_DIVOP_DIV  = 2'b00;
    localparam logic [1:0] CPU6_DIVOP_DIVU = 2'b01;
    localparam logic [1:0] CPU6_DIVOP_REM  = 2'b10;
    localparam logic [1:0] CPU6_DIVOP_REMU = 2'b11;

    // Result for divide-by-zero or signed overflow; op[1] selects remainder.
    function automatic logic [CPU6_XLEN-1:0] cpu6_div_special(
        input logic                 is_rem,
        input logic                 b_zero,
        input logic [CPU6_XLEN-1:0] a
    );
        if (is_rem)
            return b_zero ? a : '0;
        else
            return b_zero ? '1 : {1'b1, {(CPU6_XLEN-1){1'b0}}};
    endfunction

endpackage

// File: rtl/cpu6_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only if it is non-negative.
module cpu6_div_step
    import cpu6_div_pkg::*;
(
    input  logic [CPU6_XLEN:0]   i_r,
    input  logic [CPU6_XLEN-1:0] i_q,
    input  logic [CPU6_XLEN-1:0] i_divisor,
    output logic [CPU6_XLEN:0]   o_r,
    output logic [CPU6_XLEN-1:0] o_q
);

    logic [CPU6_XLEN+1:0] w_shift;
    logic [CPU6_XLEN+1:0] w_t;

    // One spare top bit so the borrow of the trial subtract is explicit.
    assign w_shift = {i_r, i_q[CPU6_XLEN-1]};
    assign w_t     = w_shift - {2'b00, i_divisor};

    always_comb begin
        if (!w_t[CPU6_XLEN+1]) begin
            o_r = w_t[CPU6_XLEN:0];
            o_q = {i_q[CPU6_XLEN-2:0], 1'b1};
        end else begin
            o_r = w_shift[CPU6_XLEN:0];
            o_q = {i_q[CPU6_XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/cpu6_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a
// killable valid/ready request/response. Define CPU6_DIV_FASTPATH_EN to
// resolve divide-by-zero and signed overflow at accept time.
module cpu6_div
    import cpu6_div_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [CPU6_XLEN-1:0] in_a,
    input  logic [CPU6_XLEN-1:0] in_b,
    input  logic                 kill,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CPU6_XLEN-1:0] out_y,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    div_state_t           r_state;
    div_state_t           w_next;
    logic                 r_out_valid;
    logic [CPU6_XLEN-1:0] r_y;
    logic [CPU6_XLEN:0]   r_rem;
    logic [CPU6_XLEN-1:0] r_q;
    logic [CPU6_XLEN-1:0] r_b;
    logic [4:0]           r_cnt;
    logic [1:0]           r_op;
    logic                 r_a_neg;
    logic                 r_sign_diff;
    logic                 r_b_zero;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_signed_in;
    logic                 w_b_zero_in;
    logic                 w_ovf_in;
    logic [CPU6_XLEN-1:0] w_abs_a;
    logic [CPU6_XLEN-1:0] w_abs_b;
    logic [CPU6_XLEN:0]   w_step_r;
    logic [CPU6_XLEN-1:0] w_step_q;
    logic [CPU6_XLEN-1:0] w_quo_fix;
    logic [CPU6_XLEN-1:0] w_rem_fix;
    logic [CPU6_XLEN-1:0] w_fix_y;
`ifdef CPU6_DIV_FASTPATH_EN
    logic                 w_fast;
    assign w_fast = w_b_zero_in | w_ovf_in;
`endif

    // Signed ops are DIV/REM, i.e. op[0] clear.
    assign w_signed_in = ~in_op[0];
    assign w_b_zero_in = (in_b == '0);
    assign w_ovf_in    = w_signed_in && (in_a == {1'b1, {(CPU6_XLEN-1){1'b0}}}) && (in_b == '1);
    assign w_abs_a     = (w_signed_in && in_a[CPU6_XLEN-1]) ? (~in_a + 1'b1) : in_a;
    assign w_abs_b     = (w_signed_in && in_b[CPU6_XLEN-1]) ? (~in_b + 1'b1) : in_b;

    cpu6_div_step u_step (
        .i_r       (r_rem),
        .i_q       (r_q),
        .i_divisor (r_b),
        .o_r       (w_step_r),
        .o_q       (w_step_q)
    );

    assign w_quo_fix = (~r_op[0] & r_sign_diff) ? (~r_q + 1'b1) : r_q;
    assign w_rem_fix = (~r_op[0] & r_a_neg) ? (~r_rem[CPU6_XLEN-1:0] + 1'b1) : r_rem[CPU6_XLEN-1:0];
    assign w_fix_y   = (r_b_zero || r_ovf) ? cpu6_div_special(r_op[1], r_b_zero, w_rem_fix)
                                           : (r_op[1] ? w_rem_fix : w_quo_fix);

    always_comb begin
        w_next   = r_state;
        in_ready = (r_state == IDLE) && !kill;
        w_accept = in_valid && in_ready;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef CPU6_DIV_FASTPATH_EN
                    w_next = w_fast ? DONE : CALC;
`else
                    w_next = CALC;
`endif
                end
            end
            CALC:    if (r_cnt == 5'd0) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // Flush wins over every handshake.
        if (kill) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y         <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_op        <= '0;
            r_a_neg     <= 1'b0;
            r_sign_diff <= 1'b0;
            r_b_zero    <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (!kill) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op        <= in_op;
                        r_a_neg     <= in_a[CPU6_XLEN-1];
                        r_sign_diff <= in_a[CPU6_XLEN-1] ^ in_b[CPU6_XLEN-1];
                        r_b_zero    <= w_b_zero_in;
                        r_ovf       <= w_ovf_in;
                        r_rem       <= '0;
                        r_q         <= w_abs_a;
                        r_b         <= w_abs_b;
                        r_cnt       <= 5'd31;
`ifdef CPU6_DIV_FASTPATH_EN
                        if (w_fast) r_y <= cpu6_div_special(in_op[1], w_b_zero_in, in_a);
`endif
                    end
                end
                CALC: begin
                    r_rem <= w_step_r;
                    r_q   <= w_step_q;
                    r_cnt <= r_cnt - 5'd1;
                end
                FIX:     r_y <= w_fix_y;
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_y;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cpu6_div.sv
// Directed self-checking bench for cpu6_div: unsigned/signed results,
// RISC-V special cases, latency, backpressure, kill and async reset.
module tb_cpu6_div;
  import cpu6_div_pkg::*;

  localparam int LAT_FULL = 33;
`ifdef CPU6_DIV_FASTPATH_EN
  localparam int LAT_SPECIAL = 0;
`else
  localparam int LAT_SPECIAL = 33;
`endif
  localparam int WAIT_LIMIT = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  cpu6_div dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request at a negedge; return just after the accept edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Edges counted after the accept edge until out_valid is seen.
  task automatic wait_result(output logic [31:0] y, output int lat);
    lat = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < WAIT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    y = out_y;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] y, output int lat);
    start_op(op, a, b);
    wait_result(y, lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; kill = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_y !== 32'h0) begin n_fail++; $display("FAIL reset_out_y: got %h expected 00000000", out_y); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [1:0] op[4];
    logic [31:0] a[4], b[4], e[4];
    logic [31:0] y;
    int lat;
    op[0] = CPU6_DIVOP_DIVU; a[0] = 32'd100;        b[0] = 32'd7;          e[0] = 32'd14;
    op[1] = CPU6_DIVOP_REMU; a[1] = 32'd100;        b[1] = 32'd7;          e[1] = 32'd2;
    op[2] = CPU6_DIVOP_DIVU; a[2] = 32'hFFFFFFFF;   b[2] = 32'h10;         e[2] = 32'h0FFFFFFF;
    op[3] = CPU6_DIVOP_DIVU; a[3] = 32'h80000000;   b[3] = 32'hFFFFFFFF;   e[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      do_op(op[i], a[i], b[i], y, lat);
      n_checks++; if (y !== e[i]) begin n_fail++; $display("FAIL unsigned[%0d]_y: got %h expected %h", i, y, e[i]); end
      n_checks++; if (lat != LAT_FULL) begin n_fail++; $display("FAIL unsigned[%0d]_latency: got %0d expected %0d", i, lat, LAT_FULL); end
    end
  endtask

  task automatic test_signed();
    logic [1:0] op[5];
    logic [31:0] a[5], b[5], e[5];
    logic [31:0] y;
    int lat;
    op[0] = CPU6_DIVOP_DIV; a[0] = -32'sd100; b[0] = 32'd7;      e[0] = 32'hFFFFFFF2;
    op[1] = CPU6_DIVOP_REM; a[1] = -32'sd100; b[1] = 32'd7;      e[1] = 32'hFFFFFFFE;
    op[2] = CPU6_DIVOP_REM; a[2] = 32'd100;   b[2] = -32'sd7;    e[2] = 32'd2;
    op[3] = CPU6_DIVOP_DIV; a[3] = 32'd100;   b[3] = -32'sd7;    e[3] = 32'hFFFFFFF2;
    op[4] = CPU6_DIVOP_DIV; a[4] = -32'sd100; b[4] = -32'sd7;    e[4] = 32'd14;
    for (int i = 0; i < 5; i++) begin
      do_op(op[i], a[i], b[i], y, lat);
      n_checks++; if (y !== e[i]) begin n_fail++; $display("FAIL signed[%0d]_y: got %h expected %h", i, y, e[i]); end
      n_checks++; if (lat != LAT_FULL) begin n_fail++; $display("FAIL signed[%0d]_latency: got %0d expected %0d", i, lat, LAT_FULL); end
    end
  endtask

  task automatic test_special();
    logic [1:0] op[6];
    logic [31:0] a[6], b[6], e[6];
    logic [31:0] y;
    int lat;
    op[0] = CPU6_DIVOP_DIV;  a[0] = 32'd5;        b[0] = 32'd0;        e[0] = 32'hFFFFFFFF;
    op[1] = CPU6_DIVOP_REMU; a[1] = 32'd5;        b[1] = 32'd0;        e[1] = 32'd5;
    op[2] = CPU6_DIVOP_DIVU; a[2] = 32'd5;        b[2] = 32'd0;        e[2] = 32'hFFFFFFFF;
    op[3] = CPU6_DIVOP_REM;  a[3] = -32'sd5;      b[3] = 32'd0;        e[3] = 32'hFFFFFFFB;
    op[4] = CPU6_DIVOP_DIV;  a[4] = 32'h80000000; b[4] = 32'hFFFFFFFF; e[4] = 32'h80000000;
    op[5] = CPU6_DIVOP_REM;  a[5] = 32'h80000000; b[5] = 32'hFFFFFFFF; e[5] = 32'h0;
    for (int i = 0; i < 6; i++) begin
      do_op(op[i], a[i], b[i], y, lat);
      n_checks++; if (y !== e[i]) begin n_fail++; $display("FAIL special[%0d]_y: got %h expected %h", i, y, e[i]); end
      n_checks++; if (lat != LAT_SPECIAL) begin n_fail++; $display("FAIL special[%0d]_latency: got %0d expected %0d", i, lat, LAT_SPECIAL); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] y;
    int lat;
    start_op(CPU6_DIVOP_DIVU, 32'd100, 32'd7);
    wait_result(y, lat);
    n_checks++; if (lat != LAT_FULL) begin n_fail++; $display("FAIL bp_latency: got %0d expected %0d", lat, LAT_FULL); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (out_y !== 32'd14) begin n_fail++; $display("FAIL bp_hold_y[%0d]: got %h expected 0000000e", i, out_y); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL bp_release_state: got %0d expected 0", dbg_state); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_kill();
    logic [31:0] y;
    int lat;
    int seen;
    start_op(CPU6_DIVOP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL kill_in_ready_comb: got %b expected 0", in_ready); end
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL kill_in_ready_after: got %b expected 1", in_ready); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL kill_state: got %0d expected 0", dbg_state); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL kill_no_out_valid: got %0d valid cycles expected 0", seen); end
    do_op(CPU6_DIVOP_DIVU, 32'd9, 32'd3, y, lat);
    n_checks++; if (y !== 32'd3) begin n_fail++; $display("FAIL kill_next_op_y: got %h expected 00000003", y); end
    n_checks++; if (lat != LAT_FULL) begin n_fail++; $display("FAIL kill_next_op_latency: got %0d expected %0d", lat, LAT_FULL); end

    // kill while idle must block the accept
    @(negedge clk);
    in_valid = 1'b1; in_op = CPU6_DIVOP_DIVU; in_a = 32'd9; in_b = 32'd3; kill = 1'b1;
    @(posedge clk);
    #1 begin in_valid = 1'b0; kill = 1'b0; end
    @(negedge clk);
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL kill_idle_blocks_accept: got state %0d expected 0", dbg_state); end

    // kill in DONE overrides a simultaneous out_ready
    start_op(CPU6_DIVOP_DIVU, 32'd50, 32'd5);
    wait_result(y, lat);
    n_checks++; if (y !== 32'd10) begin n_fail++; $display("FAIL kill_done_y: got %h expected 0000000a", y); end
    kill = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 begin kill = 1'b0; out_ready = 1'b0; end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL kill_done_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL kill_done_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_async_reset();
    start_op(CPU6_DIVOP_DIVU, 32'd77, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL async_reset_state: got %0d expected 0", dbg_state); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_y !== 32'h0) begin n_fail++; $display("FAIL async_reset_out_y: got %h expected 00000000", out_y); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_backpressure();
    test_kill();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
